// File: rtl/sram_access_arbiter_pkg.sv
// Shared constants and types for the SRAM access arbiter: bus widths, read-return tags
// and the requester index map used across the decoder.
package sram_arb_pkg;

    localparam int SRAM_ADDR_W       = 18;
    localparam int SRAM_DATA_W       = 16;
    localparam int SRAM_READ_LATENCY = 2;
    localparam int TAG_ID_W          = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } sram_tag_t;

    typedef enum logic [TAG_ID_W-1:0] {
        REQ_VGA  = 3'd0,
        REQ_UART = 3'd1,
        REQ_M1   = 3'd2,
        REQ_M2   = 3'd3
    } req_id_e;

    // Next round-robin pointer after serving idx, wrapping at n.
    function automatic logic [TAG_ID_W-1:0] wrap_inc(input logic [TAG_ID_W-1:0] idx, input int n);
        if (int'(idx) >= n - 1) begin
            return '0;
        end
        return idx + TAG_ID_W'(1);
    endfunction

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Requester-side and SRAM-controller-side signals of the arbiter, bundled as one bus.
// master = requesters plus SRAM controller model, slave = the arbiter itself.
interface sram_access_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]             req_i;
    logic [NUM_REQ-1:0]             we_i;
    logic [NUM_REQ-1:0]             lock_i;
    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_i;
    logic [NUM_REQ-1:0][DATA_W-1:0] wdata_i;
    logic [NUM_REQ-1:0]             grant_o;
    logic [NUM_REQ-1:0]             rdata_valid_o;
    logic [DATA_W-1:0]              rdata_o;
    logic [ADDR_W-1:0]              SRAM_address_o;
    logic [DATA_W-1:0]              SRAM_write_data_o;
    logic                           SRAM_we_n_o;
    logic [DATA_W-1:0]              SRAM_read_data_i;

    modport master (
        output req_i, we_i, lock_i, addr_i, wdata_i, SRAM_read_data_i,
        input  grant_o, rdata_valid_o, rdata_o, SRAM_address_o, SRAM_write_data_o, SRAM_we_n_o
    );

    modport slave (
        input  req_i, we_i, lock_i, addr_i, wdata_i, SRAM_read_data_i,
        output grant_o, rdata_valid_o, rdata_o, SRAM_address_o, SRAM_write_data_o, SRAM_we_n_o
    );
endinterface

// File: rtl/sram_access_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first eligible requester at or
// after ptr, wrapping to the lowest eligible index when nothing lies at or above ptr.
module rr_pick
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [NUM_REQ-1:0]  mask,
    input  logic [TAG_ID_W-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant
);
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] at_or_after;
    logic [NUM_REQ-1:0] upper;
    logic [NUM_REQ-1:0] pick_src;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_window
            assign at_or_after[gi] = (TAG_ID_W'(gi) >= ptr);
        end
    endgenerate

    assign eligible = req & mask;
    assign upper    = eligible & at_or_after;
    assign pick_src = (|upper) ? upper : eligible;
    // Isolate the lowest set bit.
    assign grant    = pick_src & (~pick_src + NUM_REQ'(1));

endmodule

// File: rtl/sram_access_arbiter.sv
// Issues one SRAM access per clock: strict priority requester, then lock owner, then
// round-robin; read data is returned with a one-hot tag READ_LATENCY clocks after issue.
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_W       = SRAM_ADDR_W,
    parameter int DATA_W       = SRAM_DATA_W,
    parameter int READ_LATENCY = SRAM_READ_LATENCY,
    parameter int PRIO_REQ     = 0
) (
    input logic                  Clock_50,
    input logic                  Resetn,
    sram_access_arbiter_if.slave bus
);
    logic [NUM_REQ-1:0]  prio_mask;
    logic [NUM_REQ-1:0]  rr_mask;
    logic [NUM_REQ-1:0]  rr_grant;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  lock_oh_reg;
    logic [NUM_REQ-1:0]  lock_oh_next;
    logic [NUM_REQ-1:0]  rdata_valid;
    logic [TAG_ID_W-1:0] rr_ptr_reg;
    logic [TAG_ID_W-1:0] rr_ptr_next;
    logic [TAG_ID_W-1:0] grant_idx;
    logic                prio_hit;
    logic                lock_hit;
    logic                accept;
    logic                grant_we;
    logic                grant_lock;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [ADDR_W-1:0]   address_reg;
    logic [DATA_W-1:0]   write_data_reg;
    logic                we_n_reg;
    sram_tag_t           tag_next;
    sram_tag_t           tag_pipe_reg [READ_LATENCY];

    // PRIO_REQ == NUM_REQ leaves prio_mask all zero, so everyone joins round-robin.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_masks
            assign prio_mask[gi]   = (gi == PRIO_REQ);
            assign rdata_valid[gi] = tag_pipe_reg[READ_LATENCY-1].valid &&
                                     (tag_pipe_reg[READ_LATENCY-1].id == TAG_ID_W'(gi));
        end
    endgenerate

    assign rr_mask  = ~prio_mask;
    assign prio_hit = |(bus.req_i & prio_mask);
    assign lock_hit = |(bus.req_i & lock_oh_reg);

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req   (bus.req_i),
        .mask  (rr_mask),
        .ptr   (rr_ptr_reg),
        .grant (rr_grant)
    );

    always_comb begin
        grant = rr_grant;
        if (prio_hit) begin
            grant = prio_mask;
        end else if (lock_hit) begin
            grant = lock_oh_reg;
        end
    end

    // Select only the granted requester so X on idle requesters never reaches the SRAM.
    always_comb begin
        grant_idx  = '0;
        sel_addr   = '0;
        sel_wdata  = '0;
        grant_we   = 1'b0;
        grant_lock = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx  = TAG_ID_W'(i);
                sel_addr   = bus.addr_i[i];
                sel_wdata  = bus.wdata_i[i];
                grant_we   = bus.we_i[i];
                grant_lock = bus.lock_i[i];
            end
        end
    end

    assign accept = |grant;

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (accept && !prio_hit && !lock_hit) begin
            rr_ptr_next = wrap_inc(grant_idx, NUM_REQ);
        end
    end

    always_comb begin
        lock_oh_next = lock_oh_reg;
        if (accept && grant_lock) begin
            lock_oh_next = grant;
        end else if (accept && |(grant & lock_oh_reg)) begin
            lock_oh_next = '0;
        end else if (|lock_oh_reg && !lock_hit) begin
            lock_oh_next = '0;
        end
    end

    assign tag_next.valid = accept && !grant_we;
    assign tag_next.id    = grant_idx;

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            rr_ptr_reg     <= '0;
            lock_oh_reg    <= '0;
            address_reg    <= '0;
            write_data_reg <= '0;
            we_n_reg       <= 1'b1;
        end else begin
            rr_ptr_reg  <= rr_ptr_next;
            lock_oh_reg <= lock_oh_next;
            we_n_reg    <= !(accept && grant_we);
            if (accept) begin
                address_reg <= sel_addr;
            end
            if (accept && grant_we) begin
                write_data_reg <= sel_wdata;
            end
        end
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_pipe_reg[i] <= '0;
            end
        end else begin
            tag_pipe_reg[0] <= tag_next;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_pipe_reg[i] <= tag_pipe_reg[i-1];
            end
        end
    end

    assign bus.grant_o           = grant;
    assign bus.rdata_valid_o     = rdata_valid;
    assign bus.rdata_o           = bus.SRAM_read_data_i;
    assign bus.SRAM_address_o    = address_reg;
    assign bus.SRAM_write_data_o = write_data_reg;
    assign bus.SRAM_we_n_o       = we_n_reg;

endmodule
